// File: rtl/keystone_pkg.sv
// Shared types and constants for the keystone frame controller.
// Holds the FSM state encoding, the packed 8x32 homography coefficient
// type (H11 in the lowest word, then H12, H13, H21, H22, H23, H31, H32),
// the coefficient width and the identity homography loaded at reset.
package keystone_pkg;

    localparam int COEF_W = 32;
    localparam int COEF_N = 8;
    localparam int POS_W  = 11;

    // Word index of each coefficient inside h_coef_t
    localparam int IDX_H11 = 0;
    localparam int IDX_H22 = 4;

    typedef logic [COEF_N-1:0][COEF_W-1:0] h_coef_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // 1.0 in the datapath's fixed-point coefficient format
    localparam logic [COEF_W-1:0] COEF_ONE = 32'h0100_0000;

    // Identity homography: H11 = H22 = 1.0, everything else 0
    localparam h_coef_t H_IDENTITY = {
        32'h0000_0000,  // H32
        32'h0000_0000,  // H31
        32'h0000_0000,  // H23
        COEF_ONE,       // H22
        32'h0000_0000,  // H21
        32'h0000_0000,  // H13
        32'h0000_0000,  // H12
        COEF_ONE        // H11
    };

endpackage

// File: rtl/keystone_pos_counter.sv
// Pixel/line position tracker for the snooped video stream.
// Tracks the position of the next expected pixel and flags frame start,
// mid-frame restart and end-of-frame events for the controller FSM.
// Optional feature: KEYSTONE_FRAME_ERR_EN enables line-length checking
// (early/late end-of-line detection with a forced wrap on a missing tlast).
module keystone_pos_counter
    import keystone_pkg::*;
#(
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080
)
(
    input  logic             aclk,
    input  logic             areset,
    input  logic             aclken,
    input  logic             clear,
    input  logic             idle,
    input  logic             active,
    input  logic             beat,
    input  logic             tuser,
    input  logic             tlast,
    output logic [POS_W-1:0] x_cnt,
    output logic [POS_W-1:0] y_cnt,
    output logic             sof,
    output logic             sof_mid,
    output logic             eof
`ifdef KEYSTONE_FRAME_ERR_EN
    ,
    output logic [1:0]       line_err
`endif
);

    localparam logic [POS_W-1:0] Y_LAST = POS_W'(IMG_HEIGHT - 1);
`ifdef KEYSTONE_FRAME_ERR_EN
    localparam logic [POS_W-1:0] X_LAST = POS_W'(IMG_WIDTH - 1);
`endif

    logic at_origin;
    logic last_line;
    logic eol;
    logic restart;

    // Decode frame events from the current position and the beat flags.
    // A tuser beat takes priority over everything else on that beat.
    always_comb begin
        at_origin = (x_cnt == '0) && (y_cnt == '0);
        last_line = (y_cnt == Y_LAST);
        sof       = beat && idle && tuser;
        sof_mid   = beat && active && tuser && !at_origin;
        restart   = sof || sof_mid;
`ifdef KEYSTONE_FRAME_ERR_EN
        // A missing tlast at the last column still wraps, so the frame
        // stays aligned to the configured geometry.
        eol         = tlast || (x_cnt == X_LAST);
        line_err    = 2'b00;
        line_err[0] = beat && active && !sof_mid && tlast && (x_cnt != X_LAST);
        line_err[1] = beat && active && !sof_mid && !tlast && (x_cnt == X_LAST);
`else
        eol       = tlast;
`endif
        // Frame ends on the line wrap of the last line
        eof       = beat && active && !sof_mid && eol && last_line;
    end

    // Advance the position on every accepted beat inside a frame
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (aclken) begin
            if (clear) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (restart) begin
                x_cnt <= POS_W'(1);
                y_cnt <= '0;
            end else if (beat && active) begin
                if (eol) begin
                    x_cnt <= '0;
                    y_cnt <= last_line ? '0 : y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keystone_frame_ctrl.sv
// Keystone frame controller: shadow-to-active coefficient commit that only
// takes effect between frames, frame position tracking of the snooped input
// stream, soft-reset flush sequencing and sticky stream error flags.
// Optional feature: KEYSTONE_FRAME_ERR_EN enables line-length error flags
// err_flags[1:0]; without it those bits read as 0 and only sof_mid is kept.
//
// Stream handshake: the block only observes the stream. A beat is counted
// when snp_tvalid and snp_tready are both high on an edge where aclken is
// high; snp_tuser marks the first pixel of a frame, snp_tlast the last
// pixel of a line. Nothing here ever drives or stalls snp_tready.
module keystone_frame_ctrl
    import keystone_pkg::*;
#(
    parameter int IMG_WIDTH    = 1920,
    parameter int IMG_HEIGHT   = 1080,
    parameter int FLUSH_CYCLES = 16
)
(
    input  logic             aclk,
    input  logic             areset,
    input  logic             aclken,
    input  logic             sw_reset,
    input  logic [255:0]     cfg_h,
    input  logic             cfg_en,
    input  logic             cfg_commit,
    input  logic             snp_tvalid,
    input  logic             snp_tready,
    input  logic             snp_tuser,
    input  logic             snp_tlast,
    output h_coef_t          h_active,
    output logic             en_active,
    output logic             cfg_pending,
    output logic             dp_flush,
    output logic             frame_active,
    output logic [POS_W-1:0] x_cnt,
    output logic [POS_W-1:0] y_cnt,
    output logic             frame_done,
    output logic [2:0]       err_flags,
    output state_t           dbg_state
);

    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

    state_t               state;
    logic [FLUSH_W-1:0]   flush_cnt;
    h_coef_t              stage_h;
    logic                 stage_en;
    logic                 err_sof;
`ifdef KEYSTONE_FRAME_ERR_EN
    logic [1:0]           err_line;
    logic [1:0]           line_err;
`endif

    logic beat;
    logic sof;
    logic sof_mid;
    logic eof;
    logic apply_now;
    logic cnt_clear;

    assign beat      = snp_tvalid && snp_tready && aclken;
    assign cnt_clear = sw_reset || (state == ST_FLUSH);

    // Apply a pending (or same-cycle) commit only between frames: while
    // idle or on the end-of-frame beat. A soft reset holds it back so the
    // pending commit survives the flush.
    assign apply_now = !sw_reset && (cfg_pending || cfg_commit) &&
                       ((state == ST_IDLE) || eof);

    assign frame_active = (state == ST_ACTIVE);
    assign dbg_state    = state;

`ifdef KEYSTONE_FRAME_ERR_EN
    assign err_flags = {err_sof, err_line};
`else
    assign err_flags = {err_sof, 2'b00};
`endif

    keystone_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .aclk     (aclk),
        .areset   (areset),
        .aclken   (aclken),
        .clear    (cnt_clear),
        .idle     (state == ST_IDLE),
        .active   (state == ST_ACTIVE),
        .beat     (beat),
        .tuser    (snp_tuser),
        .tlast    (snp_tlast),
        .x_cnt    (x_cnt),
        .y_cnt    (y_cnt),
        .sof      (sof),
        .sof_mid  (sof_mid),
        .eof      (eof)
`ifdef KEYSTONE_FRAME_ERR_EN
        ,
        .line_err (line_err)
`endif
    );

    // Frame FSM with commit staging/apply, flush sequencing and error flags
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= ST_IDLE;
            flush_cnt   <= '0;
            dp_flush    <= 1'b0;
            frame_done  <= 1'b0;
            err_sof     <= 1'b0;
`ifdef KEYSTONE_FRAME_ERR_EN
            err_line    <= 2'b00;
`endif
            h_active    <= H_IDENTITY;
            en_active   <= 1'b0;
            stage_h     <= H_IDENTITY;
            stage_en    <= 1'b0;
            cfg_pending <= 1'b0;
        end else if (aclken) begin
            frame_done <= 1'b0;

            // Latest commit always wins the staging register
            if (cfg_commit) begin
                stage_h     <= cfg_h;
                stage_en    <= cfg_en;
                cfg_pending <= 1'b1;
            end

            if (apply_now) begin
                h_active    <= cfg_commit ? h_coef_t'(cfg_h) : stage_h;
                en_active   <= cfg_commit ? cfg_en : stage_en;
                cfg_pending <= 1'b0;
            end

            if (sw_reset) begin
                // Held sw_reset keeps reloading, so the flush restarts
                state     <= ST_FLUSH;
                flush_cnt <= FLUSH_LOAD;
                dp_flush  <= 1'b1;
                err_sof   <= 1'b0;
`ifdef KEYSTONE_FRAME_ERR_EN
                err_line  <= 2'b00;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sof) begin
                            state <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (sof_mid) begin
                            err_sof <= 1'b1;
                        end
`ifdef KEYSTONE_FRAME_ERR_EN
                        err_line <= err_line | line_err;
`endif
                        if (eof) begin
                            state      <= ST_IDLE;
                            frame_done <= 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        if (flush_cnt == '0) begin
                            state    <= ST_IDLE;
                            dp_flush <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keystone_frame_ctrl.sv
// Testbench for keystone_frame_ctrl on a 4x2 frame geometry.
// Expected pixel positions are queued as each beat is driven and compared
// once the DUT has taken the beat; control outputs are checked in between.
module tb_keystone_frame_ctrl;
    import keystone_pkg::*;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FL = 16;

`ifdef KEYSTONE_FRAME_ERR_EN
    localparam logic [2:0] EARLY_EXP = 3'b001;
`else
    localparam logic [2:0] EARLY_EXP = 3'b000;
`endif

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic          areset;
    logic          aclken;
    logic          sw_reset;
    logic [255:0]  cfg_h;
    logic          cfg_en;
    logic          cfg_commit;
    logic          snp_tvalid;
    logic          snp_tready;
    logic          snp_tuser;
    logic          snp_tlast;
    h_coef_t       h_active;
    logic          en_active;
    logic          cfg_pending;
    logic          dp_flush;
    logic          frame_active;
    logic [10:0]   x_cnt;
    logic [10:0]   y_cnt;
    logic          frame_done;
    logic [2:0]    err_flags;
    state_t        dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int flush_len;

    logic [21:0]  exp_q[$];
    logic [255:0] h_id;
    logic [255:0] h_cfg1;
    logic [255:0] h_cfg2;

    keystone_frame_ctrl #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .FLUSH_CYCLES (FL)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .aclken       (aclken),
        .sw_reset     (sw_reset),
        .cfg_h        (cfg_h),
        .cfg_en       (cfg_en),
        .cfg_commit   (cfg_commit),
        .snp_tvalid   (snp_tvalid),
        .snp_tready   (snp_tready),
        .snp_tuser    (snp_tuser),
        .snp_tlast    (snp_tlast),
        .h_active     (h_active),
        .en_active    (en_active),
        .cfg_pending  (cfg_pending),
        .dp_flush     (dp_flush),
        .frame_active (frame_active),
        .x_cnt        (x_cnt),
        .y_cnt        (y_cnt),
        .frame_done   (frame_done),
        .err_flags    (err_flags),
        .dbg_state    (dbg_state)
    );

    // frame_done is high for one full cycle, so one negedge sample per pulse
    always @(negedge aclk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        logic [21:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got %0h expected a queued position", tag, {y_cnt, x_cnt});
        end else begin
            e = exp_q.pop_front();
            check(tag, {y_cnt, x_cnt}, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // One beat; expected next position {ey, ex} is queued when driven
    task automatic beat(input logic user, input logic last, input logic commit,
                        input logic [10:0] ex, input logic [10:0] ey);
        @(negedge aclk);
        snp_tvalid = 1'b1;
        snp_tuser  = user;
        snp_tlast  = last;
        cfg_commit = commit;
        exp_q.push_back({ey, ex});
        @(posedge aclk);
        #1;
        snp_tvalid = 1'b0;
        snp_tuser  = 1'b0;
        snp_tlast  = 1'b0;
        cfg_commit = 1'b0;
        sb_pop("pos");
    endtask

    // Well-formed W x H frame; optional commit on beat index commit_at
    task automatic send_frame(input int commit_at, input logic [255:0] h_before);
        int idx;
        int nx;
        int ny;
        idx = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (x == W - 1) begin
                    nx = 0;
                    ny = (y == H - 1) ? 0 : y + 1;
                end else begin
                    nx = x + 1;
                    ny = y;
                end
                beat((x == 0) && (y == 0), x == W - 1, idx == commit_at, 11'(nx), 11'(ny));
                if (idx < W * H - 1) begin
                    check("frame_active", frame_active, 1'b1);
                    if (commit_at >= 0 && idx >= commit_at) begin
                        check("pending_mid", cfg_pending, 1'b1);
                        check("h_hold_mid", h_active, h_before);
                    end
                end
                idx++;
            end
        end
        check("frame_done_pulse", frame_done, 1'b1);
        check("state_after_eof", dbg_state, ST_IDLE);
        tick(1);
        check("frame_done_low", frame_done, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        h_id = '0;
        h_id[0*32 +: 32] = 32'h0100_0000;
        h_id[4*32 +: 32] = 32'h0100_0000;
        h_cfg1 = h_id;
        h_cfg1[2*32 +: 32] = 32'h0000_0010;
        h_cfg2 = h_id;
        h_cfg2[2*32 +: 32] = 32'h0000_0020;
        h_cfg2[7*32 +: 32] = 32'($urandom_range(1, 255));

        areset     = 1'b1;
        aclken     = 1'b1;
        sw_reset   = 1'b0;
        cfg_h      = '0;
        cfg_en     = 1'b0;
        cfg_commit = 1'b0;
        snp_tvalid = 1'b0;
        snp_tready = 1'b1;
        snp_tuser  = 1'b0;
        snp_tlast  = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;

        // Reset values
        check("rst_h_active", h_active, h_id);
        check("rst_en_active", en_active, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_pos", {y_cnt, x_cnt}, 22'd0);
        check("rst_err", err_flags, 3'b000);
        check("rst_flush", dp_flush, 1'b0);
        check("rst_pending", cfg_pending, 1'b0);
        check("rst_done", frame_done, 1'b0);

        // Clock enable low: a start-of-frame beat must not be taken
        aclken = 1'b0; snp_tvalid = 1'b1; snp_tuser = 1'b1;
        tick(1);
        check("clken_state", dbg_state, ST_IDLE);
        check("clken_x", x_cnt, 11'd0);
        snp_tvalid = 1'b0; snp_tuser = 1'b0; aclken = 1'b1;

        // Clean 4x2 frame
        send_frame(-1, h_id);
        check("frame1_err", err_flags, 3'b000);
        check("frame1_done_cnt", done_cnt, 1);

        // Commit on beat 3 held until the end-of-frame beat
        cfg_h = h_cfg1; cfg_en = 1'b1;
        send_frame(2, h_id);
        check("commit_h_applied", h_active, h_cfg1);
        check("commit_en_applied", en_active, 1'b1);
        check("commit_pending_clr", cfg_pending, 1'b0);

        // Short line: tlast at x_cnt=2
        beat(1'b1, 1'b0, 1'b0, 11'd1, 11'd0);
        beat(1'b0, 1'b0, 1'b0, 11'd2, 11'd0);
        beat(1'b0, 1'b1, 1'b0, 11'd0, 11'd1);
        check("early_eol_err", err_flags, EARLY_EXP);
        beat(1'b0, 1'b0, 1'b0, 11'd1, 11'd1);
        beat(1'b0, 1'b0, 1'b0, 11'd2, 11'd1);
        beat(1'b0, 1'b0, 1'b0, 11'd3, 11'd1);
        beat(1'b0, 1'b1, 1'b0, 11'd0, 11'd0);
        check("short_frame_done", frame_done, 1'b1);
        check("short_err_sticky", err_flags, EARLY_EXP);

        // Soft reset mid-frame with a commit pending
        cfg_h = h_cfg2; cfg_en = 1'b0;
        beat(1'b1, 1'b0, 1'b0, 11'd1, 11'd0);
        beat(1'b0, 1'b0, 1'b1, 11'd2, 11'd0);
        check("swr_pending_before", cfg_pending, 1'b1);
        @(negedge aclk);
        sw_reset = 1'b1;
        @(posedge aclk);
        #1;
        sw_reset = 1'b0;
        snp_tvalid = 1'b1;  // start-of-frame beats offered during the flush
        snp_tuser  = 1'b1;
        check("swr_state", dbg_state, ST_FLUSH);
        check("swr_err", err_flags, 3'b000);
        check("swr_pos", {y_cnt, x_cnt}, 22'd0);
        check("swr_pending_kept", cfg_pending, 1'b1);
        flush_len = 0;
        for (int i = 0; i < 40; i++) begin
            if (dp_flush !== 1'b1) break;
            flush_len++;
            tick(1);
        end
        snp_tvalid = 1'b0;
        snp_tuser  = 1'b0;
        check("flush_len", flush_len, FL);
        check("post_flush_state", dbg_state, ST_IDLE);
        check("post_flush_pos", {y_cnt, x_cnt}, 22'd0);
        check("post_flush_pending", cfg_pending, 1'b1);
        check("post_flush_h_hold", h_active, h_cfg1);
        tick(1);
        check("idle_apply_pending", cfg_pending, 1'b0);
        check("idle_apply_h", h_active, h_cfg2);
        check("idle_apply_en", en_active, 1'b0);

        // Start-of-frame in the middle of a line
        beat(1'b1, 1'b0, 1'b0, 11'd1, 11'd0);
        beat(1'b0, 1'b0, 1'b0, 11'd2, 11'd0);
        beat(1'b1, 1'b0, 1'b0, 11'd1, 11'd0);
        check("sof_mid_err", err_flags, 3'b100);
        check("sof_mid_state", dbg_state, ST_ACTIVE);

        tick(2);
        check("total_frames_done", done_cnt, 3);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
